// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: md_op/ALU codes, forward selects,
// i_ex field offsets and the multiply/divide FSM state.
package exec_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // i_ex = {md_op[2:0], alu_control[3:0], b_i, s_u, shamt}
    localparam int unsigned EX_SHAMT_BIT = 0;
    localparam int unsigned EX_SU_BIT    = 1;
    localparam int unsigned EX_BI_BIT    = 2;
    localparam int unsigned EX_ALU_LSB   = 3;
    localparam int unsigned EX_MD_LSB    = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/execution_muldiv_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier and,
// when EXEC_DIV_EN is defined, a restoring divider; NB_REG cycles per op.
module muldiv_unit
    import exec_pkg::*;
#(
    parameter int unsigned NB_REG = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [NB_REG-1:0] a,
    input  logic [NB_REG-1:0] b,
    output logic              busy,
    output logic [NB_REG-1:0] hi,
    output logic [NB_REG-1:0] lo
);
    localparam int unsigned NB_CNT = $clog2(NB_REG);

    md_state_t           state, state_next;
    logic [NB_CNT-1:0]   cnt;
    logic [2*NB_REG-1:0] acc, acc_step, prod_fix;
    logic [NB_REG-1:0]   opd, addend, a_mag, b_mag, hi_res, lo_res;
    logic [NB_REG:0]     sum;
    logic                is_signed, a_neg, b_neg, go, neg_lo;
`ifdef EXEC_DIV_EN
    logic                div_sel, is_div, neg_hi, div_zero;
    logic [NB_REG-1:0]   dividend;
    logic [NB_REG:0]     trial;
    assign div_sel = (op == MD_DIV) || (op == MD_DIVU);
    assign go      = start && (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
`else
    assign go      = start && (op inside {MD_MULT, MD_MULTU});
`endif

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = is_signed & a[NB_REG-1];
    assign b_neg     = is_signed & b[NB_REG-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign busy      = (state == ST_BUSY);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (go) state_next = ST_BUSY;
            ST_BUSY: if (cnt == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
    always_comb begin
        addend   = acc[0] ? opd : '0;
        sum      = {1'b0, acc[2*NB_REG-1:NB_REG]} + {1'b0, addend};
        acc_step = {sum, acc[NB_REG-1:1]};
`ifdef EXEC_DIV_EN
        trial = {acc[2*NB_REG-1:NB_REG], acc[NB_REG-1]} - {1'b0, opd};
        if (is_div) begin
            if (!trial[NB_REG]) acc_step = {trial[NB_REG-1:0], acc[NB_REG-2:0], 1'b1};
            else                acc_step = {acc[2*NB_REG-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        prod_fix = neg_lo ? -acc_step : acc_step;
        hi_res   = prod_fix[2*NB_REG-1:NB_REG];
        lo_res   = prod_fix[NB_REG-1:0];
`ifdef EXEC_DIV_EN
        if (is_div) begin
            if (div_zero) begin
                hi_res = dividend;
                lo_res = '1;
            end else begin
                lo_res = neg_lo ? -acc_step[NB_REG-1:0] : acc_step[NB_REG-1:0];
                hi_res = neg_hi ? -acc_step[2*NB_REG-1:NB_REG] : acc_step[2*NB_REG-1:NB_REG];
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opd    <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef EXEC_DIV_EN
            is_div   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
`endif
        end else if (state == ST_IDLE && go) begin
            cnt    <= NB_CNT'(NB_REG - 1);
            neg_lo <= a_neg ^ b_neg;
            acc    <= {{NB_REG{1'b0}}, b_mag};
            opd    <= a_mag;
`ifdef EXEC_DIV_EN
            is_div   <= div_sel;
            neg_hi   <= a_neg;
            div_zero <= (b == '0);
            dividend <= a;
            if (div_sel) begin
                acc <= {{NB_REG{1'b0}}, a_mag};
                opd <= b_mag;
            end
`endif
        end else if (state == ST_BUSY) begin
            cnt <= cnt - NB_CNT'(1);
            acc <= acc_step;
            if (cnt == '0) begin
                hi <= hi_res;
                lo <= lo_res;
            end
        end
    end

endmodule

// File: rtl/execution_muldiv.sv
// MIPS execute stage: forwarding, single-cycle ALU into EX/MEM, and an iterative
// mul/div unit that stalls upstream. Divider present only with EXEC_DIV_EN.
module execution_muldiv
    import exec_pkg::*;
#(
    parameter int unsigned NB_REG   = 32,
    parameter int unsigned NB_INM   = 16,
    parameter int unsigned NB_SHAMT = 5,
    parameter int unsigned NB_EX    = 10,
    parameter int unsigned NB_MEM   = 5,
    parameter int unsigned NB_WB    = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_REG-1:0]   i_a,
    input  logic [NB_REG-1:0]   i_b,
    input  logic [NB_INM-1:0]   i_inm,
    input  logic [NB_SHAMT-1:0] i_shamt,
    input  logic [NB_EX-1:0]    i_ex,
    input  logic [NB_MEM-1:0]   i_mem,
    input  logic [NB_WB-1:0]    i_wb,
    input  logic [NB_REG-1:0]   i_pc,
    input  logic [1:0]          i_fwd_a,
    input  logic [1:0]          i_fwd_b,
    input  logic [NB_REG-1:0]   i_wb_data,
    output logic [NB_REG-1:0]   o_alu,
    output logic [NB_REG-1:0]   o_b,
    output logic [NB_REG-1:0]   o_pc,
    output logic [NB_MEM-1:0]   o_mem,
    output logic [NB_WB-1:0]    o_wb,
    output logic                o_stall
);
    localparam int unsigned NB_SH = $clog2(NB_REG);

    logic [2:0]        md_op;
    logic [3:0]        alu_ctl;
    logic              use_imm, imm_unsigned, use_shamt, busy;
    logic [NB_REG-1:0] fwd_a, store_data, ext_inm, op_a, op_b, alu_result, hi, lo;

    assign md_op        = i_ex[EX_MD_LSB +: 3];
    assign alu_ctl      = i_ex[EX_ALU_LSB +: 4];
    assign use_imm      = i_ex[EX_BI_BIT];
    assign imm_unsigned = i_ex[EX_SU_BIT];
    assign use_shamt    = i_ex[EX_SHAMT_BIT];

    always_comb begin
        case (i_fwd_a)
            FWD_ALU: fwd_a = o_alu;
            FWD_WB:  fwd_a = i_wb_data;
            default: fwd_a = i_a;
        endcase
        case (i_fwd_b)
            FWD_ALU: store_data = o_alu;
            FWD_WB:  store_data = i_wb_data;
            default: store_data = i_b;
        endcase
    end

    assign ext_inm = imm_unsigned ? {{(NB_REG-NB_INM){1'b0}}, i_inm}
                                  : {{(NB_REG-NB_INM){i_inm[NB_INM-1]}}, i_inm};
    assign op_a    = use_shamt ? {{(NB_REG-NB_SHAMT){1'b0}}, i_shamt} : fwd_a;
    assign op_b    = use_imm ? ext_inm : store_data;

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            ALU_SLL:  alu_result = op_b << op_a[NB_SH-1:0];
            ALU_SRL:  alu_result = op_b >> op_a[NB_SH-1:0];
            ALU_SRA:  alu_result = $unsigned($signed(op_b) >>> op_a[NB_SH-1:0]);
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_NOR:  alu_result = ~(op_a | op_b);
            ALU_SLT:  alu_result = {{(NB_REG-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(NB_REG-1){1'b0}}, op_a < op_b};
            ALU_LUI:  alu_result = op_b << NB_INM;
            default:  alu_result = '0;
        endcase
    end

    // Mul/div operands come from the forwarded registers, not the shamt/immediate path
    muldiv_unit #(.NB_REG(NB_REG)) u_muldiv (
        .clock (i_clock),
        .reset (i_reset),
        .start (i_valid & ~busy),
        .op    (md_op),
        .a     (fwd_a),
        .b     (store_data),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    assign o_stall = busy;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_alu <= '0;
            o_b   <= '0;
            o_pc  <= '0;
            o_mem <= '0;
            o_wb  <= '0;
        end else if (busy) begin
            o_mem <= '0;
            o_wb  <= '0;
        end else if (i_valid) begin
            o_alu <= (md_op == MD_MFHI) ? hi : (md_op == MD_MFLO) ? lo : alu_result;
            o_b   <= store_data;
            o_pc  <= i_pc;
            o_mem <= i_mem;
            o_wb  <= i_wb;
        end
    end

endmodule
